// File: rtl/key_event_ctrl_pkg.sv
// Shared constants for the key event controller: register word addresses,
// CTRL bit positions and the CTRL reset value.
package key_event_pkg;

  localparam logic [1:0] ADDR_DATA = 2'd0;
  localparam logic [1:0] ADDR_MASK = 2'd1;
  localparam logic [1:0] ADDR_EDGE = 2'd2;
  localparam logic [1:0] ADDR_CTRL = 2'd3;

  localparam int CTRL_FALL_EN = 0;
  localparam int CTRL_RISE_EN = 1;

  // Presses are captured out of reset, releases are not.
  localparam logic [1:0] CTRL_RESET = 2'b01;

endpackage

// File: rtl/key_event_ctrl_if.sv
// Avalon-MM slave bus bundle for the key event controller.
interface key_event_ctrl_if;
  logic        chipselect;
  logic [1:0]  address;
  logic        read;
  logic        write;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport master (
    output chipselect, address, read, write, writedata,
    input  readdata
  );

  modport slave (
    input  chipselect, address, read, write, writedata,
    output readdata
  );
endinterface

// File: rtl/key_event_ctrl_debounce.sv
// One-key synchroniser and debouncer. The accepted level only follows the
// synchronised input after it has disagreed for DEBOUNCE_CYCLES consecutive
// cycles; fall/rise pulse on the cycle the accepted level changes.
module key_debounce #(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic stable,
  output logic fall,
  output logic rise
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             meta_q, meta_d;
  logic             sync_q, sync_d;
  logic             stable_q, stable_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Two-stage synchroniser, disagreement counter and level acceptance.
  always_comb begin
    meta_d   = raw;
    sync_d   = meta_q;
    stable_d = stable_q;
    cnt_d    = cnt_q;
    fall     = 1'b0;
    rise     = 1'b0;
    if (sync_q == stable_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_LAST) begin
      stable_d = sync_q;
      cnt_d    = '0;
      fall     = stable_q & ~sync_q;
      rise     = ~stable_q & sync_q;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // State flops; keys idle high (released) out of reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      meta_q   <= 1'b1;
      sync_q   <= 1'b1;
      stable_q <= 1'b1;
      cnt_q    <= '0;
    end else begin
      meta_q   <= meta_d;
      sync_q   <= sync_d;
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
    end
  end

  assign stable = stable_q;

endmodule

// File: rtl/key_event_ctrl.sv
// Push-button event controller: per-key debounce, edge capture with W1C
// clear, maskable level interrupt and a 4-word Avalon-MM register file.
module key_event_ctrl
  import key_event_pkg::*;
#(
  parameter int WIDTH           = 4,
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic             clk,
  input  logic             reset,
  key_event_ctrl_if.slave  bus,
  input  logic [WIDTH-1:0] in_port,
  output logic [WIDTH-1:0] key_state,
  output logic             irq
);

  logic [WIDTH-1:0] fall, rise, events, w1c;
  logic [WIDTH-1:0] mask_q, mask_d;
  logic [WIDTH-1:0] edge_q, edge_d;
  logic [1:0]       ctrl_q, ctrl_d;
  logic             irq_q, irq_d;
  logic [31:0]      readdata_q, readdata_d;
  logic             wr_en, rd_en;
  logic             unused_wdata;

  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_key
    key_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
      .clk    (clk),
      .reset  (reset),
      .raw    (in_port[gi]),
      .stable (key_state[gi]),
      .fall   (fall[gi]),
      .rise   (rise[gi])
    );
  end

  assign wr_en        = bus.chipselect & bus.write;
  assign rd_en        = bus.chipselect & bus.read;
  assign unused_wdata = ^bus.writedata;

  // Register writes, edge capture (set beats W1C clear) and irq reduction.
  always_comb begin
    mask_d = mask_q;
    ctrl_d = ctrl_q;
    w1c    = '0;
    if (wr_en && bus.address == ADDR_MASK) mask_d = bus.writedata[WIDTH-1:0];
    if (wr_en && bus.address == ADDR_CTRL) ctrl_d = bus.writedata[1:0];
    if (wr_en && bus.address == ADDR_EDGE) w1c    = bus.writedata[WIDTH-1:0];
    events = (fall & {WIDTH{ctrl_q[CTRL_FALL_EN]}})
           | (rise & {WIDTH{ctrl_q[CTRL_RISE_EN]}});
    edge_d = (edge_q & ~w1c) | events;
    irq_d  = |(edge_q & mask_q);
  end

  // Read mux; the registered output returns to zero when not being read.
  always_comb begin
    readdata_d = '0;
    if (rd_en) begin
      case (bus.address)
        ADDR_DATA: readdata_d = 32'(key_state);
        ADDR_MASK: readdata_d = 32'(mask_q);
        ADDR_EDGE: readdata_d = 32'(edge_q);
        ADDR_CTRL: readdata_d = {30'b0, ctrl_q};
        default:   readdata_d = '0;
      endcase
    end
  end

  // Register file, capture, interrupt and read-data flops.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mask_q     <= '0;
      edge_q     <= '0;
      ctrl_q     <= CTRL_RESET;
      irq_q      <= 1'b0;
      readdata_q <= '0;
    end else begin
      mask_q     <= mask_d;
      edge_q     <= edge_d;
      ctrl_q     <= ctrl_d;
      irq_q      <= irq_d;
      readdata_q <= readdata_d;
    end
  end

  assign bus.readdata = readdata_q;
  assign irq          = irq_q;

endmodule

// File: tb/tb_key_event_ctrl.sv
// Bench for key_event_ctrl: register table, hand-written corner sequences,
// then random keys and bus traffic against a window-based reference model.
module tb_key_event_ctrl;
  import key_event_pkg::*;

  localparam int W = 4;
  localparam int D = 4;

  logic         clk = 1'b0;
  logic         reset;
  logic [W-1:0] in_port;
  logic [W-1:0] key_state;
  logic         irq;

  key_event_ctrl_if bus ();

  key_event_ctrl #(
    .WIDTH           (W),
    .DEBOUNCE_CYCLES (D)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus),
    .in_port   (in_port),
    .key_state (key_state),
    .irq       (irq)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  typedef struct {
    string       name;
    logic        cs;
    logic        wr;
    logic        rd;
    logic [1:0]  addr;
    logic [31:0] wdata;
    logic [31:0] exp;
  } vec_t;
  vec_t vecs[$];

  // Reference model state
  bit           model_on = 1'b0;
  logic [W-1:0] m_hist[$];
  logic [W-1:0] m_stable, m_mask, m_edge;
  logic [1:0]   m_ctrl;
  logic         m_irq;
  logic [31:0]  m_rd;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  task automatic model_reset();
    m_hist.delete();
    m_stable = '1;
    m_mask   = '0;
    m_edge   = '0;
    m_ctrl   = 2'b01;
    m_irq    = 1'b0;
    m_rd     = '0;
  endtask

  // One clock edge of the model, using the inputs present at that edge.
  // A key's accepted level flips once the synchronised input (in_port two
  // edges late, ones before any sample exists) has differed from it for D
  // edges in a row.
  task automatic model_step();
    logic [W-1:0] flip, fall, rise, setv, w1c;
    logic [31:0]  rd_n;
    bit           all_diff;
    logic         s;
    if (reset) begin
      model_reset();
      return;
    end
    m_hist.push_front(in_port);
    if (m_hist.size() > D + 2) void'(m_hist.pop_back());
    flip = '0;
    for (int k = 0; k < W; k++) begin
      all_diff = 1'b1;
      for (int j = 0; j < D; j++) begin
        s = (2 + j < m_hist.size()) ? m_hist[2+j][k] : 1'b1;
        if (s == m_stable[k]) all_diff = 1'b0;
      end
      flip[k] = all_diff;
    end
    fall = flip & m_stable;
    rise = flip & ~m_stable;
    setv = (fall & {W{m_ctrl[0]}}) | (rise & {W{m_ctrl[1]}});
    rd_n = '0;
    if (bus.chipselect && bus.read) begin
      case (bus.address)
        2'd0:    rd_n = 32'(m_stable);
        2'd1:    rd_n = 32'(m_mask);
        2'd2:    rd_n = 32'(m_edge);
        default: rd_n = {30'b0, m_ctrl};
      endcase
    end
    w1c = (bus.chipselect && bus.write && bus.address == 2'd2) ? bus.writedata[W-1:0] : '0;
    m_irq  = |(m_edge & m_mask);
    m_edge = (m_edge & ~w1c) | setv;
    if (bus.chipselect && bus.write && bus.address == 2'd1) m_mask = bus.writedata[W-1:0];
    if (bus.chipselect && bus.write && bus.address == 2'd3) m_ctrl = bus.writedata[1:0];
    m_stable = m_stable ^ flip;
    m_rd     = rd_n;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (model_on) model_step();
  endtask

  task automatic bus_set(input logic cs, input logic wr, input logic rd,
                         input logic [1:0] a, input logic [31:0] d);
    bus.chipselect = cs;
    bus.write      = wr;
    bus.read       = rd;
    bus.address    = a;
    bus.writedata  = d;
  endtask

  task automatic bus_idle();
    bus_set(1'b0, 1'b0, 1'b0, 2'd0, 32'd0);
  endtask

  task automatic wr_reg(input logic [1:0] a, input logic [31:0] d);
    bus_set(1'b1, 1'b1, 1'b0, a, d);
    tick();
    bus_idle();
  endtask

  task automatic rd_check(input string name, input logic [1:0] a, input logic [31:0] exp);
    bus_set(1'b1, 1'b0, 1'b1, a, 32'd0);
    tick();
    check(name, bus.readdata, exp);
    bus_idle();
  endtask

  task automatic add_vec(input string n, input logic cs, input logic wr, input logic rd,
                         input logic [1:0] a, input logic [31:0] d, input logic [31:0] e);
    vec_t v;
    v.name = n; v.cs = cs; v.wr = wr; v.rd = rd; v.addr = a; v.wdata = d; v.exp = e;
    vecs.push_back(v);
  endtask

  initial begin
    logic [W-1:0] ks_and;

    reset   = 1'b1;
    in_port = '1;
    bus_idle();
    repeat (3) tick();
    check("rst_readdata", bus.readdata, 32'd0);
    check("rst_irq", 32'(irq), 32'd0);
    check("rst_key_state", 32'(key_state), 32'hF);
    reset = 1'b0;
    tick();

    // Register access table: {name, cs, wr, rd, addr, wdata, expected readdata}
    add_vec("ctrl_reset",   1, 0, 1, ADDR_CTRL, 32'd0,         32'h1);
    add_vec("mask_reset",   1, 0, 1, ADDR_MASK, 32'd0,         32'h0);
    add_vec("data_idle",    1, 0, 1, ADDR_DATA, 32'd0,         32'hF);
    add_vec("edge_reset",   1, 0, 1, ADDR_EDGE, 32'd0,         32'h0);
    add_vec("mask_wr",      1, 1, 0, ADDR_MASK, 32'hFFFF_FFF5, 32'h0);
    add_vec("mask_rd",      1, 0, 1, ADDR_MASK, 32'd0,         32'h5);
    add_vec("mask_wr_nocs", 0, 1, 0, ADDR_MASK, 32'hFFFF_FFFF, 32'h0);
    add_vec("mask_rd2",     1, 0, 1, ADDR_MASK, 32'd0,         32'h5);
    add_vec("rd_nocs",      0, 0, 1, ADDR_MASK, 32'd0,         32'h0);
    add_vec("ctrl_wr",      1, 1, 0, ADDR_CTRL, 32'hFFFF_FFFE, 32'h0);
    add_vec("ctrl_rd",      1, 0, 1, ADDR_CTRL, 32'd0,         32'h2);
    add_vec("edge_w1c_nop", 1, 1, 0, ADDR_EDGE, 32'hFFFF_FFFF, 32'h0);
    add_vec("edge_rd",      1, 0, 1, ADDR_EDGE, 32'd0,         32'h0);
    add_vec("data_wr_ro",   1, 1, 0, ADDR_DATA, 32'hFFFF_FFF0, 32'h0);
    add_vec("data_rd",      1, 0, 1, ADDR_DATA, 32'd0,         32'hF);
    add_vec("ctrl_wr_fall", 1, 1, 0, ADDR_CTRL, 32'h1,         32'h0);
    add_vec("mask_wr_1",    1, 1, 0, ADDR_MASK, 32'h1,         32'h0);
    add_vec("mask_rd_1",    1, 0, 1, ADDR_MASK, 32'd0,         32'h1);
    foreach (vecs[i]) begin
      bus_set(vecs[i].cs, vecs[i].wr, vecs[i].rd, vecs[i].addr, vecs[i].wdata);
      tick();
      check(vecs[i].name, bus.readdata, vecs[i].exp);
    end
    bus_idle();
    tick();

    // Clean press of key 0: level accepted D+2 edges after the pin changes.
    in_port = 4'hE;
    repeat (D + 1) tick();
    check("press_not_early", 32'(key_state), 32'hF);
    tick();
    check("press_key_state", 32'(key_state), 32'hE);
    check("press_irq_lag", 32'(irq), 32'd0);
    tick();
    check("press_irq", 32'(irq), 32'd1);
    rd_check("press_edge", ADDR_EDGE, 32'h1);
    in_port = 4'hF;
    repeat (D + 3) tick();
    check("release_key_state", 32'(key_state), 32'hF);
    rd_check("release_no_rise", ADDR_EDGE, 32'h1);
    wr_reg(ADDR_EDGE, 32'h1);
    tick();
    check("clear_irq", 32'(irq), 32'd0);
    rd_check("clear_edge", ADDR_EDGE, 32'h0);

    // Glitch on key 2 one cycle shorter than the debounce window.
    in_port = 4'hB;
    repeat (D - 1) tick();
    in_port = 4'hF;
    ks_and  = '1;
    repeat (10) begin
      tick();
      ks_and = ks_and & key_state;
    end
    check("glitch_key_state", 32'(ks_and), 32'hF);
    rd_check("glitch_edge", ADDR_EDGE, 32'h0);

    // Rise-only capture on key 1.
    wr_reg(ADDR_CTRL, 32'h2);
    in_port = 4'hD;
    repeat (D + 3) tick();
    check("rise_press_ks", 32'(key_state), 32'hD);
    rd_check("rise_press_edge", ADDR_EDGE, 32'h0);
    in_port = 4'hF;
    repeat (D + 3) tick();
    rd_check("rise_release_edge", ADDR_EDGE, 32'h2);
    check("rise_unmasked_irq", 32'(irq), 32'd0);
    wr_reg(ADDR_EDGE, 32'h2);
    wr_reg(ADDR_CTRL, 32'h1);

    // W1C clear landing on the same edge as a new fall: the set must win.
    in_port = 4'hE;
    repeat (D + 3) tick();
    check("race_setup_irq", 32'(irq), 32'd1);
    in_port = 4'hF;
    repeat (D + 3) tick();
    in_port = 4'hE;
    repeat (D + 1) tick();
    bus_set(1'b1, 1'b1, 1'b0, ADDR_EDGE, 32'h1);
    tick();
    bus_idle();
    check("race_flip_edge", 32'(key_state), 32'hE);
    tick();
    check("race_irq", 32'(irq), 32'd1);
    rd_check("race_edge", ADDR_EDGE, 32'h1);
    wr_reg(ADDR_EDGE, 32'h1);
    check("w1c_irq_lag", 32'(irq), 32'd1);
    tick();
    check("w1c_irq", 32'(irq), 32'd0);

    // Simultaneous presses on keys 0 and 3, only key 3 unmasked.
    in_port = 4'hF;
    repeat (D + 3) tick();
    wr_reg(ADDR_MASK, 32'h8);
    in_port = 4'h6;
    repeat (D + 3) tick();
    check("multi_ks", 32'(key_state), 32'h6);
    rd_check("multi_edge", ADDR_EDGE, 32'h9);
    check("multi_irq", 32'(irq), 32'd1);
    wr_reg(ADDR_EDGE, 32'h8);
    tick();
    check("multi_clear_irq", 32'(irq), 32'd0);
    rd_check("multi_edge_left", ADDR_EDGE, 32'h1);

    // Reset in the middle of a debounce, with readdata and irq active.
    in_port = 4'hB;
    repeat (D + 3) tick();
    check("pre_reset_ks", 32'(key_state), 32'hB);
    wr_reg(ADDR_MASK, 32'h1);
    tick();
    check("pre_reset_irq", 32'(irq), 32'd1);
    in_port = 4'hF;
    bus_set(1'b1, 1'b0, 1'b1, ADDR_MASK, 32'd0);
    repeat (3) tick();
    check("pre_reset_rd", bus.readdata, 32'h1);
    reset = 1'b1;
    #1;
    check("reset_readdata", bus.readdata, 32'd0);
    check("reset_irq", 32'(irq), 32'd0);
    check("reset_key_state", 32'(key_state), 32'hF);
    bus_idle();
    repeat (2) tick();
    reset = 1'b0;
    rd_check("reset_ctrl", ADDR_CTRL, 32'h1);
    rd_check("reset_edge", ADDR_EDGE, 32'h0);
    rd_check("reset_mask", ADDR_MASK, 32'h0);

    // Random keys and bus traffic against the model.
    model_on = 1'b1;
    in_port  = '1;
    reset    = 1'b1;
    tick();
    reset = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      int r;
      if ($urandom_range(0, 5) == 0) in_port[$urandom_range(0, W - 1)] ^= 1'b1;
      r = $urandom_range(0, 9);
      if (r < 4)      bus_set($urandom_range(0, 1) == 1, 1'b0, 1'b0, 2'($urandom_range(0, 3)), $urandom);
      else if (r < 7) bus_set($urandom_range(0, 7) != 0, 1'b0, 1'b1, 2'($urandom_range(0, 3)), 32'd0);
      else            bus_set($urandom_range(0, 7) != 0, 1'b1, 1'b0, 2'($urandom_range(0, 3)), $urandom);
      if (c == 1500) reset = 1'b1;
      tick();
      reset = 1'b0;
      check("rand_key_state", 32'(key_state), 32'(m_stable));
      check("rand_irq", 32'(irq), 32'(m_irq));
      check("rand_readdata", bus.readdata, m_rd);
    end
    bus_idle();
    tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/key_event_ctrl.md
# key_event_ctrl

Debounce and event controller for the board push-buttons, sitting between the raw key pins and the Nios II Avalon-MM fabric. It synchronises and debounces each key and latches press/release events in an edge-capture register. It raises a maskable interrupt and exposes everything through a 4-word Avalon-MM slave with registered, 1-cycle-latency reads.

## Interface
Parameters:
- `WIDTH`, 4: number of keys.
- `DEBOUNCE_CYCLES`, 500000: consecutive stable cycles before a level is accepted (10 ms at 50 MHz). Must be ≥ 2.

Ports:
- `clk` input 1: single system clock.
- `reset` input 1: asynchronous, active-high reset.
- `chipselect` input 1: Avalon slave select.
- `address` input 2: word address.
- `read` input 1: read strobe.
- `write` input 1: write strobe.
- `writedata` input 32: write data.
- `readdata` output 32: registered read data.
- `in_port` input WIDTH: raw keys, active-low, asynchronous to `clk`.
- `key_state` output WIDTH: debounced key levels (1 = released).
- `irq` output 1: level interrupt, registered.

## Operation
Register map (word addresses):
- 0 DATA (RO): `key_state` in bits [WIDTH-1:0]; upper bits read 0.
- 1 IRQ_MASK (RW): bits [WIDTH-1:0]; 1 = event on that key drives `irq`.
- 2 EDGE_CAP (R/W1C): a bit is set on an enabled debounced transition and cleared by writing 1. Writing 0 has no effect.
- 3 CTRL (RW):
  - bit0 FALL_EN: capture press, i.e. 1→0.
  - bit1 RISE_EN: capture release, i.e. 0→1.
  - Other bits read 0.

Per-key debounce:
- 2-FF synchroniser produces `sync`.
- A counter clears whenever `sync == stable`; otherwise it increments.
- When `sync != stable` and the counter equals DEBOUNCE_CYCLES-1, `stable <= sync` and the counter clears.
- A glitch shorter than DEBOUNCE_CYCLES cycles therefore never reaches `stable`.
- A transition is reported on the same cycle `stable` updates:
  - fall: old 1, new 0.
  - rise: old 0, new 1.

Event and IRQ rules:
- `edge_cap[i]` sets on (fall & FALL_EN) | (rise & RISE_EN).
- If a set event and a W1C clear hit the same bit in the same cycle, set wins.
- `irq <= |(edge_cap & irq_mask)`, registered.

Bus rules:
- Writes take effect only when `chipselect & write`.
- Unused writedata bits are ignored.
- `readdata` updates every cycle with the mux output for `address` when `chipselect & read`. Otherwise it holds 0.

Reset values:
- `readdata` 0, `irq` 0, `irq_mask` 0, `edge_cap` 0, CTRL = 2'b01.
- Synchroniser flops, `stable` and `key_state` all ones; counters 0.
- Reset mid-debounce discards the partial count. No event is generated on reset release.

## Timing
- `in_port` change to `key_state` update: DEBOUNCE_CYCLES+2 cycles (2 sync + DEBOUNCE_CYCLES count), provided `in_port` holds steady.
- `key_state` update and `edge_cap` set happen on the same clock edge.
- `irq` asserts 1 cycle after `edge_cap`/`irq_mask` make the AND non-zero. It deasserts 1 cycle after the W1C write or mask clear.
- Read latency: fixed 1 cycle, no waitrequest.
- Write to IRQ_MASK/CTRL is visible on the next cycle. A CTRL change affects only transitions occurring after it.
- All WIDTH keys are independent. Simultaneous events on multiple keys all set their bits in the same cycle.

## Structure
- Shared package `key_event_pkg` holds:
  - address constants `ADDR_DATA`=0, `ADDR_MASK`=1, `ADDR_EDGE`=2, `ADDR_CTRL`=3.
  - CTRL bit indices `CTRL_FALL_EN`=0, `CTRL_RISE_EN`=1.
- One sub-module, `key_debounce`, handles one bit:
  - contents: synchroniser, counter of width $clog2(DEBOUNCE_CYCLES), `stable`, and `fall`/`rise` pulses.
  - instantiated WIDTH times in a generate loop.
- Top level contains the register file, edge-capture logic, irq flop and read mux.

## Test plan
Run with DEBOUNCE_CYCLES=4, WIDTH=4.
- Reset check: assert `reset` mid-run → `readdata`=0, `irq`=0, `key_state`=4'hF, read CTRL=32'h1 after release.
- Clean press: `in_port[0]` 1→0 held, mask=1 → `key_state[0]`=0 exactly 6 cycles later, EDGE_CAP reads 32'h1, `irq`=1 one cycle after.
- Glitch rejection: `in_port[2]` low for 3 cycles then high → `key_state` stays 4'hF, EDGE_CAP stays 0.
- Rise-only mode: CTRL=2'b10; press then release key 1 → no set on press, EDGE_CAP=32'h2 after release.
- W1C race: write EDGE_CAP=32'h1 on the cycle key 0 generates a new fall → bit 0 remains 1, `irq` stays 1. A subsequent write of 32'h1 clears it and `irq`=0 one cycle later.
- Mask/multi-key: keys 0 and 3 pressed simultaneously, mask=4'h8 → EDGE_CAP=32'h9 and `irq`=1. Clearing bit 3 only → `irq`=0 while bit 0 stays set.
